// File: rtl/arm_memory_unit.sv
// Byte-addressable synchronous RAM answering the ControlUnit's MFA/MFC four-phase
// handshake, with big-endian word access, zero-extended byte reads and range checking.
module arm_memory_unit #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        READ_WRITE,
    input  logic        WORD_BYTE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        ADDR_ERR
);

    localparam int             DEPTH    = 2 ** ADDR_BITS;
    localparam int             HI_BITS  = 32 - ADDR_BITS;
    localparam logic [3:0]     LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [3:0]             cnt_r, cnt_nxt_s;
    logic [31:0]            addr_r, wdata_r;
    logic                   rd_r, word_r;
    logic                   capture_s, access_s;
    logic                   mfc_nxt_s, err_nxt_s;
    logic [31:0]            dout_nxt_s, rdata_s;
    logic                   in_range_s;
    logic [ADDR_BITS-1:0]   byte_idx_s, w0_s, w1_s, w2_s, w3_s;
    logic [7:0]             mem_r [DEPTH];

    assign in_range_s = (addr_r[31:ADDR_BITS] == {HI_BITS{1'b0}});
    assign byte_idx_s = addr_r[ADDR_BITS-1:0];
    // Word accesses ignore the two low address bits: lanes are the aligned base | 0..3.
    assign w0_s = {addr_r[ADDR_BITS-1:2], 2'b00};
    assign w1_s = {addr_r[ADDR_BITS-1:2], 2'b01};
    assign w2_s = {addr_r[ADDR_BITS-1:2], 2'b10};
    assign w3_s = {addr_r[ADDR_BITS-1:2], 2'b11};

    // Read data path from the latched request.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (!in_range_s) begin
            rdata_s = 32'h0000_0000;
        end else if (word_r) begin
            rdata_s = {mem_r[w0_s], mem_r[w1_s], mem_r[w2_s], mem_r[w3_s]};
        end else begin
            rdata_s = {24'h00_0000, mem_r[byte_idx_s]};
        end
    end

    // Handshake FSM next-state and next-output logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        access_s    = 1'b0;
        mfc_nxt_s   = MFC;
        err_nxt_s   = ADDR_ERR;
        dout_nxt_s  = DataOut;
        case (state_r)
            ST_IDLE: begin
                if (MFA) begin
                    capture_s   = 1'b1;
                    cnt_nxt_s   = LAT_INIT;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!MFA) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    access_s    = 1'b1;
                    mfc_nxt_s   = 1'b1;
                    err_nxt_s   = !in_range_s;
                    state_nxt_s = ST_DONE;
                    if (rd_r) begin
                        dout_nxt_s = rdata_s;
                    end else begin
                        dout_nxt_s = DataOut;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                if (!MFA) begin
                    mfc_nxt_s   = 1'b0;
                    err_nxt_s   = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                mfc_nxt_s   = 1'b0;
                err_nxt_s   = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            MFC      <= 1'b0;
            ADDR_ERR <= 1'b0;
            DataOut  <= 32'h0000_0000;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            MFC      <= mfc_nxt_s;
            ADDR_ERR <= err_nxt_s;
            DataOut  <= dout_nxt_s;
        end
    end

    // Request capture; later input changes are ignored until the next request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            rd_r    <= 1'b0;
            word_r  <= 1'b0;
        end else if (capture_s) begin
            addr_r  <= Address;
            wdata_r <= DataIn;
            rd_r    <= READ_WRITE;
            word_r  <= WORD_BYTE;
        end
    end

    // Storage: the write commits on the MFC edge and survives Reset.
    always_ff @(posedge Clk) begin
        if (!Reset && access_s && !rd_r && in_range_s) begin
            if (word_r) begin
                mem_r[w0_s] <= wdata_r[31:24];
                mem_r[w1_s] <= wdata_r[23:16];
                mem_r[w2_s] <= wdata_r[15:8];
                mem_r[w3_s] <= wdata_r[7:0];
            end else begin
                mem_r[byte_idx_s] <= wdata_r[7:0];
            end
        end
    end

endmodule

// File: tb/tb_arm_memory_unit.sv
// Self-checking bench for arm_memory_unit: two instances (LATENCY 2 and 4) driven with
// directed and random handshakes, checked against a byte-array reference model.
module tb_arm_memory_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        mfa0, mfa1;
    logic        READ_WRITE, WORD_BYTE;
    logic [31:0] Address, DataIn;
    logic [31:0] dout0, dout1;
    logic        mfc0, mfc1, err0, err1;

    int total = 0;
    int bad   = 0;

    logic [7:0]  model [2][256];
    logic [31:0] dout_exp [2];

    always #5 clk = ~clk;

    arm_memory_unit #(.ADDR_BITS(8), .LATENCY(2)) dut0 (
        .Clk(clk), .Reset(Reset), .MFA(mfa0), .READ_WRITE(READ_WRITE),
        .WORD_BYTE(WORD_BYTE), .Address(Address), .DataIn(DataIn),
        .DataOut(dout0), .MFC(mfc0), .ADDR_ERR(err0)
    );

    arm_memory_unit #(.ADDR_BITS(8), .LATENCY(4)) dut1 (
        .Clk(clk), .Reset(Reset), .MFA(mfa1), .READ_WRITE(READ_WRITE),
        .WORD_BYTE(WORD_BYTE), .Address(Address), .DataIn(DataIn),
        .DataOut(dout1), .MFC(mfc1), .ADDR_ERR(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : 4;
    endfunction

    function automatic logic get_mfc(input int s);
        return (s == 0) ? mfc0 : mfc1;
    endfunction

    function automatic logic get_err(input int s);
        return (s == 0) ? err0 : err1;
    endfunction

    function automatic logic [31:0] get_dout(input int s);
        return (s == 0) ? dout0 : dout1;
    endfunction

    task automatic set_mfa(input int s, input logic v);
        if (s == 0) mfa0 = v;
        else        mfa1 = v;
    endtask

    function automatic logic [31:0] model_read(input int s, input logic wb, input logic [31:0] a);
        int b;
        if (a >= 32'd256) return 32'h0;
        if (wb) begin
            b = int'(a) - int'(a % 32'd4);
            return {model[s][b], model[s][b+1], model[s][b+2], model[s][b+3]};
        end
        return {24'h0, model[s][int'(a)]};
    endfunction

    task automatic model_write(input int s, input logic wb, input logic [31:0] a, input logic [31:0] d);
        int b;
        if (a < 32'd256) begin
            if (wb) begin
                b = int'(a) - int'(a % 32'd4);
                model[s][b]   = d[31:24];
                model[s][b+1] = d[23:16];
                model[s][b+2] = d[15:8];
                model[s][b+3] = d[7:0];
            end else begin
                model[s][int'(a)] = d[7:0];
            end
        end
    endtask

    // Full handshake on instance s; MFA is held for 'hold' extra edges after MFC.
    task automatic do_access(input int s, input logic rd, input logic wb, input logic [31:0] a,
                             input logic [31:0] d, input int hold,
                             output logic [31:0] q, output logic e);
        logic [31:0] exp_q;
        logic        exp_e;
        int          n;
        bit          got;
        exp_e = (a >= 32'd256);
        exp_q = rd ? model_read(s, wb, a) : dout_exp[s];
        @(negedge clk);
        Address = a; DataIn = d; READ_WRITE = rd; WORD_BYTE = wb;
        set_mfa(s, 1'b1);
        @(posedge clk); #1;
        chk("accept_mfc", {31'h0, get_mfc(s)}, 32'h0);
        Address = $urandom(); DataIn = $urandom();
        READ_WRITE = 1'($urandom()); WORD_BYTE = 1'($urandom());
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (get_mfc(s)) got = 1;
        end
        chk("latency", 32'(n), 32'(lat_of(s)));
        q = get_dout(s);
        e = get_err(s);
        if (got) begin
            chk("dout", q, exp_q);
            chk("addr_err", {31'h0, e}, {31'h0, exp_e});
            if (!rd) model_write(s, wb, a, d);
            dout_exp[s] = exp_q;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_mfc", {31'h0, get_mfc(s)}, 32'h1);
                chk("hold_dout", get_dout(s), exp_q);
                chk("hold_err", {31'h0, get_err(s)}, {31'h0, exp_e});
            end
        end
        @(negedge clk);
        set_mfa(s, 1'b0);
        @(posedge clk); #1;
        chk("mfc_fall", {31'h0, get_mfc(s)}, 32'h0);
        chk("err_fall", {31'h0, get_err(s)}, 32'h0);
        chk("dout_keep", get_dout(s), dout_exp[s]);
    endtask

    // Word write that is abandoned h edges after acceptance, by MFA drop or by Reset.
    task automatic abort_access(input int s, input logic [31:0] a, input logic [31:0] d,
                                input int h, input bit use_reset);
        @(negedge clk);
        Address = a; DataIn = d; READ_WRITE = 1'b0; WORD_BYTE = 1'b1;
        set_mfa(s, 1'b1);
        @(posedge clk); #1;
        chk("abort_accept", {31'h0, get_mfc(s)}, 32'h0);
        repeat (h - 1) begin
            @(posedge clk); #1;
            chk("abort_busy", {31'h0, get_mfc(s)}, 32'h0);
        end
        @(negedge clk);
        if (use_reset) Reset = 1'b1;
        else           set_mfa(s, 1'b0);
        @(posedge clk); #1;
        chk("abort_mfc", {31'h0, get_mfc(s)}, 32'h0);
        if (use_reset) begin
            chk("rst_dout", get_dout(s), 32'h0);
            chk("rst_err", {31'h0, get_err(s)}, 32'h0);
            dout_exp[0] = 32'h0;
            dout_exp[1] = 32'h0;
        end
        @(negedge clk);
        Reset = 1'b0;
        set_mfa(s, 1'b0);
        repeat (lat_of(s) + 2) begin
            @(posedge clk); #1;
            chk("abort_quiet", {31'h0, get_mfc(s)}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] q, a, d;
        logic        e, rd, wb;
        int          s, sel;

        Reset = 1'b1; mfa0 = 1'b0; mfa1 = 1'b0;
        READ_WRITE = 1'b0; WORD_BYTE = 1'b0; Address = 32'h0; DataIn = 32'h0;
        dout_exp[0] = 32'h0; dout_exp[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mfc0", {31'h0, mfc0}, 32'h0);
        chk("rst_err0", {31'h0, err0}, 32'h0);
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_mfc1", {31'h0, mfc1}, 32'h0);
        chk("rst_err1", {31'h0, err1}, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        @(negedge clk);
        Reset = 1'b0;

        // Give both memories defined contents.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 64; w++)
                do_access(k, 1'b0, 1'b1, 32'(w * 4), $urandom(), 0, q, e);

        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, q, e);
        do_access(0, 1'b1, 1'b1, 32'h10, 32'h0, 0, q, e);
        chk("s1_word", q, 32'hDEADBEEF);
        chk("s1_err", {31'h0, e}, 32'h0);

        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, q, e); chk("s2_b0", q, 32'h0000_00DE);
        do_access(0, 1'b1, 1'b0, 32'h11, 32'h0, 0, q, e); chk("s2_b1", q, 32'h0000_00AD);
        do_access(0, 1'b1, 1'b0, 32'h12, 32'h0, 0, q, e); chk("s2_b2", q, 32'h0000_00BE);
        do_access(0, 1'b1, 1'b0, 32'h13, 32'h0, 0, q, e); chk("s2_b3", q, 32'h0000_00EF);
        do_access(0, 1'b0, 1'b0, 32'h12, 32'hFFFF_FF55, 0, q, e);
        do_access(0, 1'b1, 1'b1, 32'h10, 32'h0, 0, q, e); chk("s2_merge", q, 32'hDEAD55EF);
        do_access(0, 1'b1, 1'b1, 32'h13, 32'h0, 0, q, e); chk("s3_align", q, 32'hDEAD55EF);

        do_access(0, 1'b0, 1'b1, 32'h100, 32'h12345678, 0, q, e);
        chk("s4_werr", {31'h0, e}, 32'h1);
        do_access(0, 1'b1, 1'b1, 32'h0, 32'h0, 0, q, e);
        do_access(0, 1'b1, 1'b1, 32'h100, 32'h0, 0, q, e);
        chk("s4_rdata", q, 32'h0);
        chk("s4_rerr", {31'h0, e}, 32'h1);

        do_access(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 0, q, e);
        abort_access(1, 32'h20, 32'hCAFEF00D, 2, 1'b0);
        do_access(1, 1'b1, 1'b1, 32'h20, 32'h0, 0, q, e);
        chk("s5_drop", q, 32'h11223344);
        abort_access(1, 32'h20, 32'hCAFEF00D, 2, 1'b1);
        do_access(1, 1'b1, 1'b1, 32'h20, 32'h0, 0, q, e);
        chk("s5_reset", q, 32'h11223344);

        do_access(0, 1'b1, 1'b1, 32'h10, 32'h0, 5, q, e);
        chk("s6_hold", q, 32'hDEAD55EF);
        do_access(0, 1'b1, 1'b0, 32'h11, 32'h0, 0, q, e);
        chk("s6_b2b", q, 32'h0000_00AD);

        for (int i = 0; i < 300; i++) begin
            s   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 99));
            a   = ($urandom_range(0, 9) == 0) ? ($urandom() | 32'h100) : 32'($urandom_range(0, 255));
            d   = $urandom();
            rd  = 1'($urandom());
            wb  = 1'($urandom());
            if (sel < 3)       abort_access(s, a, d, int'($urandom_range(1, lat_of(s) - 1)), 1'b1);
            else if (sel < 12) abort_access(s, a, d, int'($urandom_range(1, lat_of(s) - 1)), 1'b0);
            else               do_access(s, rd, wb, a, d, int'($urandom_range(0, 3)), q, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
